// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer constants, arbiter state encoding and small helpers.
package vga_pkg;

  localparam int unsigned PIX_W     = 12;   // 4R:4G:4B
  localparam int unsigned FB_W      = 320;
  localparam int unsigned FB_H      = 240;
  localparam int unsigned FB_ADDR_W = 17;   // ceil(log2(320*240))

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_e;

  // One-hot (up to 8 ports) to binary index; zero when no bit is set.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/frame_mem_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: searches req from ptr+1 upward, wrapping.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Walk the N candidates starting just after ptr; the first requester wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IDX_W'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/frame_mem_arbiter.sv
// Frame memory arbiter: scanout reads pre-empt everything, writers share the
// remaining cycles round-robin in bursts of at most BURST_LEN words.
module frame_mem_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = FB_ADDR_W,
  parameter int unsigned DATA_W    = PIX_W,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scan_req,
  input  logic [ADDR_W-1:0]         scan_addr,
  output logic [DATA_W-1:0]         scan_data,
  output logic                      scan_valid,
  input  logic [NUM_REQ-1:0]        wr_req,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        wr_gnt,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 4;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] own_q, own_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               rd_p_q;
  logic               scan_valid_q;
  logic [DATA_W-1:0]  scan_data_q;
  logic [ADDR_W-1:0]  last_addr_q;
  logic [DATA_W-1:0]  last_wdata_q;

  logic [NUM_REQ-1:0] pick_idle, pick_own, gnt_c, gnt_act;
  logic               any_idle, any_own;
  logic [IDX_W-1:0]   pick_idle_idx, pick_own_idx, gnt_idx;

  // Fresh arbitration from the rotating pointer (used from IDLE).
  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_idle (
    .req  (wr_req),
    .ptr  (ptr_q),
    .pick (pick_idle),
    .any  (any_idle)
  );

  // End-of-burst arbitration: pointer is the current owner, so a lone owner re-wins.
  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_own (
    .req  (wr_req),
    .ptr  (own_q),
    .pick (pick_own),
    .any  (any_own)
  );

  assign pick_idle_idx = IDX_W'(oh2idx(8'(pick_idle)));
  assign pick_own_idx  = IDX_W'(oh2idx(8'(pick_own)));

  // Next-state and same-cycle grant decision.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_c   = '0;
    if (scan_req) begin
      if (state_q == ST_WRITE) state_d = ST_HOLD;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_idle) begin
            gnt_c   = pick_idle;
            own_d   = pick_idle_idx;
            cnt_d   = CNT_W'(1);
            state_d = ST_WRITE;
          end
        end
        ST_WRITE, ST_HOLD: begin
          if ((state_q == ST_HOLD) && !wr_req[own_q]) begin
            state_d = ST_IDLE;
          end else if (wr_req[own_q] && (cnt_q != CNT_W'(BURST_LEN))) begin
            gnt_c[own_q] = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
            state_d      = ST_WRITE;
          end else begin
            // Burst over: rotate past the owner and hand over without a bubble.
            ptr_d = own_q;
            if (any_own) begin
              gnt_c   = pick_own;
              own_d   = pick_own_idx;
              cnt_d   = CNT_W'(1);
              state_d = ST_WRITE;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory port mux; reset kills any write in the same instant.
  assign gnt_act   = rst_n ? gnt_c : '0;
  assign gnt_idx   = IDX_W'(oh2idx(8'(gnt_act)));
  assign wr_gnt    = gnt_act;
  assign mem_we    = |gnt_act;
  assign mem_addr  = !rst_n   ? '0 :
                     scan_req ? scan_addr :
                     mem_we   ? wr_addr[32'(gnt_idx) * ADDR_W +: ADDR_W] :
                                last_addr_q;
  assign mem_wdata = !rst_n ? '0 :
                     mem_we ? wr_data[32'(gnt_idx) * DATA_W +: DATA_W] :
                              last_wdata_q;

  // Remember the last driven address/data so an idle port holds steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      last_addr_q  <= mem_addr;
      last_wdata_q <= mem_wdata;
    end
  end

  // Read return pipeline: track the RAM latency, then capture data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p_q       <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_data_q  <= '0;
    end else begin
      rd_p_q       <= scan_req;
      scan_valid_q <= rd_p_q;
      if (rd_p_q) scan_data_q <= mem_rdata;
    end
  end

  assign scan_valid = scan_valid_q;
  assign scan_data  = scan_data_q;

endmodule

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

Shares one single-port synchronous frame memory between the VGA scanout path and up to `NUM_REQ` game-object writers (ship, asteroids, bullets, score). Scanout reads have absolute priority so the raster never starves. Writers share the leftover cycles round-robin, in bounded bursts. The block sits between the pixel-clock domain timing logic and the frame RAM, and runs on the divided 25 MHz pixel clock.

## Interface
- `NUM_REQ`, default 4: number of writer ports, 2..8.
- `ADDR_W`, default 17: frame memory address width (320x240 words).
- `DATA_W`, default 12: pixel word (4R:4G:4B).
- `BURST_LEN`, default 4: maximum consecutive writes per grant, 1..15.
- `clk  in  1`: pixel clock; the block's only clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `scan_req  in  1`: scanout needs a read this cycle.
- `scan_addr  in  ADDR_W`: scanout read address.
- `scan_data  out  DATA_W`: registered read data.
- `scan_valid  out  1`: `scan_data` is valid.
- `wr_req  in  NUM_REQ`: per-writer request; held until granted.
- `wr_addr  in  NUM_REQ*ADDR_W`: writer i at bits [i*ADDR_W +: ADDR_W].
- `wr_data  in  NUM_REQ*DATA_W`: writer i at bits [i*DATA_W +: DATA_W].
- `wr_gnt  out  NUM_REQ`: one-hot; the write of writer i is committed this cycle.
- `mem_we  out  1`, `mem_addr  out  ADDR_W`, `mem_wdata  out  DATA_W`: memory port.
- `mem_rdata  in  DATA_W`: memory read data, 1-cycle synchronous latency.

## Operation
- Each cycle has exactly one memory owner: scan, one writer, or none.
- Scan priority: when `scan_req`=1, the memory port drives `mem_addr=scan_addr`, `mem_we=0`, and `wr_gnt=0`, regardless of arbiter state.
- Writer grant: `wr_gnt[i]`, `mem_we`, `mem_addr` and `mem_wdata` are combinational from the registered state and the current `wr_req`. A writer treats its word as consumed on any cycle in which `wr_gnt[i]`=1, and presents its next word (or drops `wr_req[i]`) from the following cycle.
- States:
  - IDLE: no owner.
  - WRITE: owner index `own` and burst count `cnt` are valid.
  - HOLD: WRITE was preempted by scan.
- Transitions:
  - IDLE → WRITE: when `scan_req`=0 and any `wr_req` is set. `own` is the first requester searching from `ptr+1` modulo `NUM_REQ`. `cnt`=1, and the grant is issued in the same cycle.
  - WRITE, `scan_req`=1 → HOLD. No grant; `cnt` is kept.
  - HOLD, `scan_req`=0 → WRITE with the same `own`, if `wr_req[own]`=1; otherwise → IDLE.
  - WRITE, `wr_req[own]`=0 → end of burst.
  - WRITE, `cnt`=`BURST_LEN` after a grant → end of burst.
  - End of burst: `ptr`←`own`, then re-arbitrate in the same cycle (zero-bubble handover). If the owner is the only requester, it starts a fresh burst.
- `ptr` resets to `NUM_REQ-1`, so writer 0 wins the first arbitration.
- Read path: a one-cycle pipeline flag `rd_p` ← `scan_req`. Then `scan_data` ← `mem_rdata` and `scan_valid` ← `rd_p`. `scan_data` keeps its old value when `scan_valid`=0.

## Timing
- Reset values (asynchronous):
  - state IDLE, `ptr`=`NUM_REQ-1`, `cnt`=0, `rd_p`=0.
  - `scan_valid`=0, `scan_data`=0.
  - `wr_gnt`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Scan read latency: read data appears 2 cycles after `scan_req`. A request at edge N gives `scan_valid`=1 after edge N+2. Sustained throughput is 1 read per cycle.
- Write latency: 0. The grant and `mem_we` occur in the cycle the request is seen.
- Simultaneous `scan_req` and writer requests: scan wins; the writer waits and loses none of its burst.
- Worst-case writer wait: the scan-active time plus `(NUM_REQ-1)*BURST_LEN` writer cycles.
- Reset asserted mid-burst: the write is aborted with no partial commit (`mem_we`=0 immediately); in-flight read data is discarded.
- Idle memory port: `mem_we`=0 and `mem_addr` holds its last value.

## Structure
- Shared package `vga_pkg`: pixel word width, framebuffer width/height/address width, and the arbiter state enum (IDLE/WRITE/HOLD).
- One sub-module, `rr_pick`: a combinational round-robin first-one finder (`req`, `ptr` → one-hot `pick`, `any`).
- All other logic stays flat in `frame_mem_arbiter`.

## Test plan
- Reset: hold `rst_n`=0 with all `wr_req`=1 → `wr_gnt`=0, `mem_we`=0, `scan_valid`=0. On release, the first grant goes to writer 0.
- Round-robin: `NUM_REQ`=4, `BURST_LEN`=4, all writers requesting, `scan_req`=0 → grants 0,0,0,0,1,1,1,1,2,…,3,0 with no idle cycles.
- Preemption: writer 2 gets 2 grants, then `scan_req`=1 for 3 cycles → 3 reads with `wr_gnt`=0. Writer 2 then gets exactly 2 more grants before writer 3.
- Read latency: `scan_addr`=0x00100 with `mem_rdata`=0xF0F → `scan_data`=0xF0F and `scan_valid`=1 exactly 2 edges after `scan_req`.
- Lone writer: only writer 1 requests for 10 words → 10 consecutive grants with no gap at the burst boundary.
- Reset mid-burst: assert `rst_n`=0 during writer 3's second grant → `mem_we` drops asynchronously. After release the arbiter is IDLE, and writer 0 has priority if requesting.
